planta_garrafa_sim: RTL and testbench
=====================================

Name: planta_garrafa_sim

Overview:
- Cycle-accurate plant emulator for the bottle fill/seal station; closes the loop around the station controller.
- Consumes the controller's EV, VE and GC.
- Produces the sensor signals PG (bottle present), CH (bottle full) and RO (cap seated), driven by a conveyor/fill/seal timing model.
- Keeps an empty-bottle stock, plus completed/rejected counters for on-board display and bench checking.

Parameters:
- TRAVEL_TICKS, 16, cycles a bottle spends on the conveyor before reaching the station.
- FILL_TICKS, 16, cycles at the station before the level sensor reports full.
- SEAL_TICKS, 8, cycles with EV=1 required before the cap seats.
- EXIT_TICKS, 4, cycles the bottle remains present after GC before it leaves.
- TIMEOUT_TICKS, 1000, maximum wait in CHEIA or VEDADA before the bottle is rejected.
- ESTOQUE_INI, 10, empty-bottle stock loaded at reset and on rec.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- habilita  in  1  level; permits starting a new bottle.
- rec  in  1  one-cycle pulse; reloads stock to ESTOQUE_INI and clears erro.
- EV  in  1  controller fill-valve output; advances the seal timer.
- VE  in  1  controller seal-valve output; informational, must equal GC.
- GC  in  1  controller bottle-complete output.
- PG  out  1  bottle-present sensor.
- CH  out  1  full sensor.
- RO  out  1  cap-seated sensor.
- estado  out  3  current plant state code.
- cont_ok  out  8  bottles completed; saturates at 255.
- cont_rej  out  8  bottles rejected; saturates at 255.
- estoque  out  8  remaining empty bottles.
- vazio  out  1  estoque==0.
- erro  out  1  sticky; set on reject, on VE!=GC, or on GC outside VEDADA.

Behaviour:
- Reset: state OCIOSO; PG=CH=RO=0, cont_ok=cont_rej=0, estoque=ESTOQUE_INI, erro=0; timers cleared.
- Outputs are registered decodes of the state: PG=1 in ENCHENDO, CHEIA, VEDADA and SAIDA; CH=1 in CHEIA, VEDADA and SAIDA; RO=1 in VEDADA and SAIDA.
- State codes: OCIOSO=0, TRANSPORTE=1, ENCHENDO=2, CHEIA=3, VEDADA=4, SAIDA=5, REJEITO=6; code 7 recovers to OCIOSO.
- OCIOSO -> TRANSPORTE when habilita && estoque!=0; estoque decrements on that edge.
- TRANSPORTE: held exactly TRAVEL_TICKS cycles, then ENCHENDO.
- ENCHENDO: held exactly FILL_TICKS cycles, then CHEIA.
- CHEIA: seal timer counts only cycles with EV=1.
  - Reaching SEAL_TICKS -> VEDADA.
  - A wait timer counts every cycle in the state; reaching TIMEOUT_TICKS first -> REJEITO.
- VEDADA: GC=1 -> SAIDA. The wait timer restarts on entry; TIMEOUT_TICKS without GC -> REJEITO.
- SAIDA: held EXIT_TICKS cycles, then OCIOSO; cont_ok increments on that edge.
- REJEITO: all sensors 0 for 1 cycle; cont_rej increments; erro sets; then OCIOSO.
- habilita only gates starts; deasserting it mid-bottle does not abort the bottle.
- rec coincident with the start decrement: rec wins (estoque=ESTOQUE_INI).
- rec and an erro-set event in the same cycle: set wins.
- Counters saturate and never wrap. estoque never underflows.
- Timer width is 16 bits; a parameter value of 0 is treated as 1.
- Reset asserted mid-bottle: immediate return to the reset values; the bottle in progress is discarded and not counted.

Decomposition:
- Shared package pkg_garrafa holds:
  - state codes as localparams (3 bits);
  - a saturating-increment function;
  - sensor-polarity constants shared with the controller.
- One natural sub-module: planta_timer. It is a 16-bit down-counter with load, enable and done, instantiated twice, for the phase/seal timer and the wait timer.

Test Plan:
All tests use TRAVEL=4, FILL=6, SEAL=3, EXIT=2, TIMEOUT=20, ESTOQUE_INI=2.
1. Nominal loop with the station controller attached, habilita=1:
   - PG rises 5 cycles after the start and CH 6 cycles later.
   - The controller raises EV; RO rises after 3 EV cycles; GC follows.
   - PG falls 2 cycles after SAIDA entry.
   - End state: cont_ok=1, estoque=1.
2. Stock exhaustion: two full loops -> cont_ok=2, estoque=0, vazio=1; the plant stays OCIOSO. A rec pulse gives estoque=2 and restarts the loop.
3. EV held 0 in CHEIA -> REJEITO after 20 cycles; PG=0 for 1 cycle; cont_rej=1, erro=1. A rec pulse then clears erro.
4. EV toggled 1,0,1,0,1 -> RO rises only after the third EV=1 cycle.
5. Reset pulse during ENCHENDO -> all outputs 0 immediately; estoque=2, cont_ok=0.
6. GC forced to 1 in ENCHENDO, or VE!=GC -> erro=1; the state sequence is unaffected.

Source files
------------

// File: rtl/pkg_garrafa.sv
// Shared definitions for the bottle fill/seal station plant emulator and its controller.
package pkg_garrafa;

    typedef enum logic [2:0] {
        StOcioso     = 3'd0,
        StTransporte = 3'd1,
        StEnchendo   = 3'd2,
        StCheia      = 3'd3,
        StVedada     = 3'd4,
        StSaida      = 3'd5,
        StRejeito    = 3'd6
    } estado_e;

    localparam logic SensorOn  = 1'b1;
    localparam logic SensorOff = 1'b0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A zero-length phase still lasts one cycle.
    function automatic logic [15:0] ticks16(input int unsigned n);
        logic [15:0] t;
        t = 16'(n);
        return (t == 16'd0) ? 16'd1 : t;
    endfunction

endpackage

// File: rtl/planta_garrafa_sim_if.sv
// Controller <-> plant signal bundle; the controller side is master, the plant is slave.
interface planta_garrafa_sim_if;

    logic       habilita;
    logic       rec;
    logic       EV;
    logic       VE;
    logic       GC;
    logic       PG;
    logic       CH;
    logic       RO;
    logic [2:0] estado;
    logic [7:0] cont_ok;
    logic [7:0] cont_rej;
    logic [7:0] estoque;
    logic       vazio;
    logic       erro;

    modport master (
        output habilita, rec, EV, VE, GC,
        input  PG, CH, RO, estado, cont_ok, cont_rej, estoque, vazio, erro
    );

    modport slave (
        input  habilita, rec, EV, VE, GC,
        output PG, CH, RO, estado, cont_ok, cont_rej, estoque, vazio, erro
    );

endinterface

// File: rtl/planta_timer.sv
// 16-bit down-counter: load has priority, done flags the last enabled cycle (count == 1).
module planta_timer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic        en_i,
    output logic        done_o
);

    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == 16'd1);

endmodule

// File: rtl/planta_garrafa_sim.sv
// Bottle station plant: conveyor/fill/seal timing model producing PG/CH/RO from EV/VE/GC.
module planta_garrafa_sim
    import pkg_garrafa::*;
#(
    parameter int unsigned TRAVEL_TICKS  = 16,
    parameter int unsigned FILL_TICKS    = 16,
    parameter int unsigned SEAL_TICKS    = 8,
    parameter int unsigned EXIT_TICKS    = 4,
    parameter int unsigned TIMEOUT_TICKS = 1000,
    parameter int unsigned ESTOQUE_INI   = 10
) (
    input logic                 clk,
    input logic                 reset,
    planta_garrafa_sim_if.slave bus
);

    localparam logic [15:0] TravelT   = ticks16(TRAVEL_TICKS);
    localparam logic [15:0] FillT     = ticks16(FILL_TICKS);
    localparam logic [15:0] SealT     = ticks16(SEAL_TICKS);
    localparam logic [15:0] ExitT     = ticks16(EXIT_TICKS);
    localparam logic [15:0] TimeoutT  = ticks16(TIMEOUT_TICKS);
    localparam logic [7:0]  EstoqueIni = 8'(ESTOQUE_INI);

    estado_e     state_d, state_q;
    logic        pg_d, pg_q, ch_d, ch_q, ro_d, ro_q;
    logic [7:0]  cont_ok_d, cont_ok_q, cont_rej_d, cont_rej_q, estoque_d, estoque_q;
    logic        erro_d, erro_q;

    logic        ph_load, ph_en, ph_done;
    logic [15:0] ph_val;
    logic        wt_load, wt_en, wt_done;
    logic        start, ok_inc, rej, erro_set;

    // Phase timer doubles as the seal timer: in CHEIA it only advances on EV cycles.
    assign ph_en = (state_q inside {StTransporte, StEnchendo, StSaida}) ||
                   ((state_q == StCheia) && bus.EV);
    assign wt_en = state_q inside {StCheia, StVedada};

    planta_timer u_phase_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (ph_load),
        .value_i (ph_val),
        .en_i    (ph_en),
        .done_o  (ph_done)
    );

    planta_timer u_wait_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (wt_load),
        .value_i (TimeoutT),
        .en_i    (wt_en),
        .done_o  (wt_done)
    );

    always_comb begin
        state_d = state_q;
        ph_load = 1'b0;
        ph_val  = 16'd0;
        wt_load = 1'b0;
        start   = 1'b0;
        ok_inc  = 1'b0;
        rej     = 1'b0;
        unique case (state_q)
            StOcioso: begin
                if (bus.habilita && (estoque_q != 8'd0)) begin
                    start   = 1'b1;
                    state_d = StTransporte;
                    ph_load = 1'b1;
                    ph_val  = TravelT;
                end
            end
            StTransporte: begin
                if (ph_done) begin
                    state_d = StEnchendo;
                    ph_load = 1'b1;
                    ph_val  = FillT;
                end
            end
            StEnchendo: begin
                if (ph_done) begin
                    state_d = StCheia;
                    ph_load = 1'b1;
                    ph_val  = SealT;
                    wt_load = 1'b1;
                end
            end
            StCheia: begin
                // A seal completing on the timeout cycle still counts as sealed.
                if (ph_done) begin
                    state_d = StVedada;
                    wt_load = 1'b1;
                end else if (wt_done) begin
                    state_d = StRejeito;
                    rej     = 1'b1;
                end
            end
            StVedada: begin
                if (bus.GC) begin
                    state_d = StSaida;
                    ph_load = 1'b1;
                    ph_val  = ExitT;
                end else if (wt_done) begin
                    state_d = StRejeito;
                    rej     = 1'b1;
                end
            end
            StSaida: begin
                if (ph_done) begin
                    state_d = StOcioso;
                    ok_inc  = 1'b1;
                end
            end
            StRejeito: state_d = StOcioso;
            default:   state_d = StOcioso;
        endcase
    end

    always_comb begin
        pg_d = (state_d inside {StEnchendo, StCheia, StVedada, StSaida}) ? SensorOn : SensorOff;
        ch_d = (state_d inside {StCheia, StVedada, StSaida}) ? SensorOn : SensorOff;
        ro_d = (state_d inside {StVedada, StSaida}) ? SensorOn : SensorOff;

        erro_set = rej || (bus.VE != bus.GC) || (bus.GC && (state_q != StVedada));
        if (erro_set) begin
            erro_d = 1'b1;
        end else if (bus.rec) begin
            erro_d = 1'b0;
        end else begin
            erro_d = erro_q;
        end

        if (bus.rec) begin
            estoque_d = EstoqueIni;
        end else if (start) begin
            estoque_d = estoque_q - 8'd1;
        end else begin
            estoque_d = estoque_q;
        end

        cont_ok_d  = ok_inc ? sat_inc8(cont_ok_q) : cont_ok_q;
        cont_rej_d = rej ? sat_inc8(cont_rej_q) : cont_rej_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StOcioso;
            pg_q       <= SensorOff;
            ch_q       <= SensorOff;
            ro_q       <= SensorOff;
            cont_ok_q  <= 8'd0;
            cont_rej_q <= 8'd0;
            estoque_q  <= EstoqueIni;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pg_q       <= pg_d;
            ch_q       <= ch_d;
            ro_q       <= ro_d;
            cont_ok_q  <= cont_ok_d;
            cont_rej_q <= cont_rej_d;
            estoque_q  <= estoque_d;
            erro_q     <= erro_d;
        end
    end

    assign bus.PG       = pg_q;
    assign bus.CH       = ch_q;
    assign bus.RO       = ro_q;
    assign bus.estado   = state_q;
    assign bus.cont_ok  = cont_ok_q;
    assign bus.cont_rej = cont_rej_q;
    assign bus.estoque  = estoque_q;
    assign bus.vazio    = (estoque_q == 8'd0);
    assign bus.erro     = erro_q;

endmodule

// File: tb/tb_planta_garrafa_sim.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized model check.
module tb_planta_garrafa_sim;

    localparam int TRAVEL = 4;
    localparam int FILL   = 6;
    localparam int SEAL   = 3;
    localparam int EXITT  = 2;
    localparam int TMO    = 20;
    localparam int INI    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    planta_garrafa_sim_if bus ();

    planta_garrafa_sim #(
        .TRAVEL_TICKS  (TRAVEL),
        .FILL_TICKS    (FILL),
        .SEAL_TICKS    (SEAL),
        .EXIT_TICKS    (EXITT),
        .TIMEOUT_TICKS (TMO),
        .ESTOQUE_INI   (INI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase number, cycles spent in it, EV cycles counted in CHEIA.
    int m_st, m_el, m_seal, m_ok, m_rej, m_stock;
    bit m_err;

    typedef struct {
        bit         hab, ev, gc;
        int         n;
        logic [2:0] est;
        logic       pg, ch, ro, erro;
        logic [7:0] ok, stock;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(bit hab, bit ev, bit gc, int n, logic [2:0] est, logic pg,
                                 logic ch, logic ro, logic erro, logic [7:0] ok,
                                 logic [7:0] stock);
        vec_t v;
        v.hab = hab; v.ev = ev; v.gc = gc; v.n = n; v.est = est;
        v.pg = pg; v.ch = ch; v.ro = ro; v.erro = erro; v.ok = ok; v.stock = stock;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_el = 0; m_seal = 0; m_ok = 0; m_rej = 0; m_stock = INI; m_err = 1'b0;
    endfunction

    function automatic void model_step();
        int nxt, seal_n;
        bit start, ok, rej, set;
        nxt = m_st; seal_n = m_seal; start = 0; ok = 0; rej = 0;
        case (m_st)
            0: if (bus.habilita && m_stock > 0) begin nxt = 1; start = 1; end
            1: if (m_el + 1 >= TRAVEL) nxt = 2;
            2: if (m_el + 1 >= FILL) nxt = 3;
            3: begin
                seal_n = m_seal + int'(bus.EV);
                if (seal_n >= SEAL) nxt = 4;
                else if (m_el + 1 >= TMO) begin nxt = 6; rej = 1; end
            end
            4: begin
                if (bus.GC) nxt = 5;
                else if (m_el + 1 >= TMO) begin nxt = 6; rej = 1; end
            end
            5: if (m_el + 1 >= EXITT) begin nxt = 0; ok = 1; end
            default: nxt = 0;
        endcase
        set = rej || (bus.VE != bus.GC) || (bus.GC && m_st != 4);
        if (set) m_err = 1'b1;
        else if (bus.rec) m_err = 1'b0;
        if (bus.rec) m_stock = INI;
        else if (start) m_stock--;
        if (ok && m_ok < 255) m_ok++;
        if (rej && m_rej < 255) m_rej++;
        if (nxt != m_st) begin m_el = 0; m_seal = 0; end
        else begin m_el++; m_seal = seal_n; end
        m_st = nxt;
    endfunction

    function automatic logic [31:0] m_pack();
        logic pg, ch, ro;
        pg = (m_st >= 2 && m_st <= 5);
        ch = (m_st >= 3 && m_st <= 5);
        ro = (m_st == 4 || m_st == 5);
        return {3'(m_st), pg, ch, ro, 8'(m_ok), 8'(m_rej), 8'(m_stock), m_stock == 0, m_err};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {bus.estado, bus.PG, bus.CH, bus.RO, bus.cont_ok, bus.cont_rej, bus.estoque,
                bus.vazio, bus.erro};
    endfunction

    task automatic set_in(input bit hab, input bit rec, input bit ev, input bit ve, input bit gc);
        bus.habilita = hab; bus.rec = rec; bus.EV = ev; bus.VE = ve; bus.GC = gc;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit);
        int n = 0;
        while (bus.estado != s && n < limit) begin cyc(); n++; end
        chk($sformatf("reach state %0d", s), bus.estado, s);
    endtask

    // Bench acts as the station controller for one complete bottle.
    task automatic run_loop(input string name);
        bit left = 0;
        int n = 0;
        set_in(1, 0, 0, 0, 0);
        while (n < 200 && !(left && bus.estado == 3'd0)) begin
            cyc(); n++;
            if (bus.estado != 3'd0) left = 1;
            set_in(!left, 0, bus.estado == 3'd3, bus.estado == 3'd4, bus.estado == 3'd4);
        end
        chk({name, " completed"}, 64'(n < 200), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int extra;
        bit gc;

        // hab ev gc  n  est pg ch ro erro ok stock
        tbl[0]  = mkv(1, 0, 0, 1, 3'd1, 0, 0, 0, 0, 8'd0, 8'd1);
        tbl[1]  = mkv(0, 0, 0, 3, 3'd1, 0, 0, 0, 0, 8'd0, 8'd1);
        tbl[2]  = mkv(0, 0, 0, 1, 3'd2, 1, 0, 0, 0, 8'd0, 8'd1);
        tbl[3]  = mkv(0, 0, 0, 5, 3'd2, 1, 0, 0, 0, 8'd0, 8'd1);
        tbl[4]  = mkv(0, 0, 0, 1, 3'd3, 1, 1, 0, 0, 8'd0, 8'd1);
        tbl[5]  = mkv(0, 1, 0, 1, 3'd3, 1, 1, 0, 0, 8'd0, 8'd1);
        tbl[6]  = mkv(0, 0, 0, 1, 3'd3, 1, 1, 0, 0, 8'd0, 8'd1);
        tbl[7]  = mkv(0, 1, 0, 1, 3'd3, 1, 1, 0, 0, 8'd0, 8'd1);
        tbl[8]  = mkv(0, 0, 0, 1, 3'd3, 1, 1, 0, 0, 8'd0, 8'd1);
        tbl[9]  = mkv(0, 1, 0, 1, 3'd4, 1, 1, 1, 0, 8'd0, 8'd1);
        tbl[10] = mkv(0, 0, 0, 2, 3'd4, 1, 1, 1, 0, 8'd0, 8'd1);
        tbl[11] = mkv(0, 0, 1, 1, 3'd5, 1, 1, 1, 0, 8'd0, 8'd1);
        tbl[12] = mkv(0, 0, 0, 1, 3'd5, 1, 1, 1, 0, 8'd0, 8'd1);
        tbl[13] = mkv(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 8'd1, 8'd1);

        set_in(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset state", dut_pack(), {3'd0, 3'b000, 8'd0, 8'd0, 8'd2, 1'b0, 1'b0});
        reset = 1'b0;

        // Nominal loop and EV toggling 1,0,1,0,1 in CHEIA.
        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].hab, 0, tbl[i].ev, tbl[i].gc, tbl[i].gc);
            repeat (tbl[i].n) cyc();
            chk($sformatf("vec%0d", i),
                {bus.estado, bus.PG, bus.CH, bus.RO, bus.erro, bus.cont_ok, bus.estoque},
                {tbl[i].est, tbl[i].pg, tbl[i].ch, tbl[i].ro, tbl[i].erro, tbl[i].ok,
                 tbl[i].stock});
        end

        // Stock exhaustion and reload.
        run_loop("second loop");
        chk("exhausted counters", {bus.cont_ok, bus.estoque, bus.vazio, bus.estado},
            {8'd2, 8'd0, 1'b1, 3'd0});
        set_in(1, 0, 0, 0, 0);
        repeat (8) cyc();
        chk("stays idle when empty", {bus.estado, bus.estoque}, {3'd0, 8'd0});
        set_in(1, 1, 0, 0, 0);
        cyc();
        chk("rec reloads stock", {bus.estado, bus.estoque, bus.vazio}, {3'd0, 8'd2, 1'b0});
        set_in(1, 0, 0, 0, 0);
        cyc();
        chk("restart after rec", {bus.estado, bus.estoque}, {3'd1, 8'd1});
        set_in(0, 0, 0, 0, 0);

        // Timeout in CHEIA with EV held low.
        wait_state(3'd3, 40);
        n = 0;
        while (bus.estado == 3'd3 && n < 40) begin cyc(); n++; end
        chk("cheia timeout cycles", n, TMO);
        chk("rejeito outputs", {bus.estado, bus.PG, bus.CH, bus.RO, bus.erro, bus.cont_rej},
            {3'd6, 3'b000, 1'b1, 8'd1});
        cyc();
        chk("after reject", {bus.estado, bus.PG, bus.cont_rej, bus.erro},
            {3'd0, 1'b0, 8'd1, 1'b1});
        set_in(0, 1, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        chk("rec clears erro", {bus.erro, bus.estoque}, {1'b0, 8'd2});

        // Protocol errors during ENCHENDO do not disturb the sequence.
        set_in(1, 0, 0, 0, 0);
        wait_state(3'd2, 20);
        set_in(0, 0, 0, 1, 1);
        cyc();
        chk("gc outside vedada", {bus.erro, bus.estado}, {1'b1, 3'd2});
        set_in(0, 1, 0, 0, 0);
        cyc();
        chk("rec clears erro again", bus.erro, 0);
        set_in(0, 0, 0, 1, 0);
        cyc();
        chk("ve differs from gc", {bus.erro, bus.estado, bus.PG}, {1'b1, 3'd2, 1'b1});
        set_in(0, 0, 0, 0, 0);

        // Asynchronous reset mid-bottle.
        #2 reset = 1'b1;
        #1;
        chk("async reset mid-bottle", dut_pack(), {3'd0, 3'b000, 8'd0, 8'd0, 8'd2, 1'b0, 1'b0});
        model_reset();
        #1 reset = 1'b0;

        // Fast controller until cont_ok saturates, then a few more bottles.
        set_in(1, 0, 0, 0, 0);
        n = 0;
        extra = 0;
        while (n < 6000 && extra < 60) begin
            cyc(); n++;
            chk("saturation run", dut_pack(), m_pack());
            if (m_ok == 255) extra++;
            set_in(1, (m_st == 0) && (m_stock == 0), m_st == 3, m_st == 4, m_st == 4);
        end
        chk("cont_ok saturated", bus.cont_ok, 255);

        // Randomized protocol against the model.
        set_in(0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 model_reset();
        #1 reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            gc = (m_st == 4) ? ($urandom_range(3) == 0) : ($urandom_range(127) == 0);
            set_in($urandom_range(9) < 8, $urandom_range(63) == 0, $urandom_range(1) == 1,
                   ($urandom_range(63) == 0) ? !gc : gc, gc);
            cyc();
            chk($sformatf("rand%0d", i), dut_pack(), m_pack());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
